piarb_deq_arb: RTL and testbench
================================

# piarb_deq_arb

Work-conserving round-robin dequeue scheduler for the PIARB PU queues.
- Tracks per-queue backlog from queue-manager enqueue acks, and per-PU credits returned by `pu_fid_done`.
- Issues paced single-cycle dequeue requests to the queue manager, which drives the hop/inst buffer-manager readout.
- Adds per-queue enable masking, credit-based PU back-pressure and sticky error flags.

## Interface
Parameters:
- NUM_Q, `NUM_OF_PU, number of PU queues.
- QID_NBITS, `PU_ID_NBITS, queue/PU id width; NUM_Q ≤ 2**QID_NBITS.
- CNT_NBITS, `PU_QUEUE_ENTRIES_NBITS+1, per-queue backlog counter width.
- PU_CREDITS, 2, max packets outstanding per PU (1..7).
- DEQ_GAP, 2, minimum cycles between deq_req pulses (1..15).

Ports:
- clk  in  1  clock.
- `RESET_SIG  in  1  asynchronous, active-high reset.
- sch_en  in  1  global issue enable, level.
- queue_en  in  NUM_Q  per-queue issue enable mask.
- enq_ack  in  1  queue manager accepted one descriptor.
- enq_ack_qid  in  QID_NBITS  queue of enq_ack.
- pu_fid_done  in  1  PU finished one packet; returns one credit.
- pu_id  in  QID_NBITS  PU of pu_fid_done.
- deq_req  out  1  single-cycle dequeue request.
- deq_qid  out  QID_NBITS  queue to dequeue; valid with deq_req.
- backlog_nz  out  NUM_Q  backlog[q] != 0, registered.
- err_credit_ovf  out  1  sticky: credit returned to a full-credit PU.
- err_backlog_ovf  out  1  sticky: enq_ack to a saturated backlog counter.

## Operation
- State per queue q:
  - backlog[q] (CNT_NBITS), reset 0.
  - credit[q] (3 bits), reset PU_CREDITS.
- Global state:
  - rr_ptr (QID_NBITS), reset 0.
  - gap_cnt (4 bits), reset 0.
- eligible[q] = backlog[q]!=0 && credit[q]!=0 && queue_en[q], for q < NUM_Q.
- FSM:
  - IDLE (gap_cnt==0): if sch_en and any eligible, issue. Winner = first eligible index searching rr_ptr, rr_ptr+1, … with wrap modulo NUM_Q (not 2**QID_NBITS).
  - Issue edge: deq_req<=1, deq_qid<=winner, backlog[winner]−1, credit[winner]−1, rr_ptr<=(winner+1) mod NUM_Q. Then gap_cnt<=DEQ_GAP−1, going to HOLD if DEQ_GAP>1, else staying in IDLE.
  - HOLD: deq_req<=0, gap_cnt decrements; gap_cnt==0 → IDLE. sch_en/queue_en changes do not abort HOLD.
- Counter update, per queue, on the same edge:
  - backlog: +1 on enq_ack, −1 on issue; both in one cycle to the same q → unchanged.
  - credit: +1 on pu_fid_done, −1 on issue; both in one cycle to the same q → unchanged.
- Saturation:
  - enq_ack with backlog at all-ones and no simultaneous issue → hold value, set err_backlog_ovf.
  - pu_fid_done with credit==PU_CREDITS and no simultaneous issue → ignore, set err_credit_ovf.
- qid ≥ NUM_Q on enq_ack or pu_fid_done: ignored, no flag.
- Sticky flags clear only on reset.
- Queue disabled via queue_en keeps accumulating backlog and is skipped by the search; rr_ptr is not advanced past it.

## Timing
- Reset: deq_req=0, deq_qid=0, backlog_nz=0, err_*=0, FSM in IDLE. Reset asserted mid-HOLD or mid-pulse drops deq_req the same cycle (async).
- All outputs registered; no combinational input-to-output path.
- Latency: enq_ack in cycle N to an eligible empty queue, FSM IDLE → deq_req in cycle N+2 (counter update at edge N+1, issue at edge N+2).
- pu_fid_done unblocking a credit-starved queue → deq_req two cycles later.
- Pulse spacing: rising edges of deq_req are ≥ DEQ_GAP cycles apart. DEQ_GAP=1 allows one per cycle.
- backlog_nz reflects counters after the same edge's update.

## Structure
- Shared package (piarb_package alongside meta_package): PIARB_SCH_CREDIT_NBITS=3, PIARB_SCH_GAP_NBITS=4, and an enum `piarb_deq_arb_state_e {IDLE, HOLD}`.
- One sub-module, piarb_rr_pick: combinational round-robin find-first over an NUM_Q request vector and start pointer. Outputs found and idx.
- Counters and FSM live in piarb_deq_arb.

## Test plan
- Reset, enq_ack q=3 ×3, sch_en=1, DEQ_GAP=2 → three deq_req qid=3, spaced 2 cycles, first at N+2; backlog_nz[3] falls after the third.
- Credit stall: PU_CREDITS=2, 5 enqs to q=1, no done → exactly 2 deq_req. pu_fid_done pu_id=1 → one more deq_req 2 cycles later.
- Fairness: backlog 4 each on q=0,5,15 (NUM_Q=16), rr_ptr=0, credits replenished every cycle → issue order 0,5,15,0,5,15,…; wrap 15→0 checked.
- Simultaneous events: enq_ack q=2 on the issue edge of q=2 with backlog 1 → backlog stays 1, next deq_req qid=2 after DEQ_GAP. pu_fid_done on an issue edge leaves credit unchanged.
- Errors: pu_fid_done to a PU at full credit → err_credit_ovf=1 and credit unchanged. Backlog saturated at all-ones plus enq_ack → err_backlog_ovf=1. Both flags hold until reset.
- Masking and reset: queue_en[7]=0 with backlog 2 → no issue. Re-enable → issue. Assert reset mid-HOLD → deq_req=0 and all counters/flags at reset values immediately.

Source files
------------

// File: rtl/piarb_deq_arb_pkg.sv
// rtl/piarb_deq_arb_pkg.sv - shared constants and state encoding for the PIARB dequeue scheduler
package piarb_deq_arb_pkg;

    localparam int PIARB_SCH_CREDIT_NBITS = 3;
    localparam int PIARB_SCH_GAP_NBITS    = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } piarb_deq_arb_state_e;

endpackage

// File: rtl/piarb_rr_pick.sv
// rtl/piarb_rr_pick.sv - combinational round-robin find-first over a request vector
module piarb_rr_pick #(
    parameter int NUM_Q     = 16,
    parameter int QID_NBITS = 4
) (
    input  logic [NUM_Q-1:0]     req,
    input  logic [QID_NBITS-1:0] start,
    output logic                 found,
    output logic [QID_NBITS-1:0] idx
);

    logic                 hi_found;
    logic [QID_NBITS-1:0] hi_idx;

    // Lowest request at or above start wins; otherwise wrap to the lowest request overall.
    // Scanning downward lets the last hit (the lowest index) stick.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int q = NUM_Q - 1; q >= 0; q--) begin
            if (req[q]) begin
                found = 1'b1;
                idx   = QID_NBITS'(q);
                if (QID_NBITS'(q) >= start) begin
                    hi_found = 1'b1;
                    hi_idx   = QID_NBITS'(q);
                end
            end
        end
        if (hi_found) begin
            idx = hi_idx;
        end
    end

endmodule

// File: rtl/piarb_deq_arb.sv
// rtl/piarb_deq_arb.sv - credit-paced work-conserving round-robin dequeue scheduler
import piarb_deq_arb_pkg::*;

module piarb_deq_arb #(
    parameter int NUM_Q      = 16,
    parameter int QID_NBITS  = 4,
    parameter int CNT_NBITS  = 5,
    parameter int PU_CREDITS = 2,
    parameter int DEQ_GAP    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sch_en,
    input  logic [NUM_Q-1:0]     queue_en,
    input  logic                 enq_ack,
    input  logic [QID_NBITS-1:0] enq_ack_qid,
    input  logic                 pu_fid_done,
    input  logic [QID_NBITS-1:0] pu_id,
    output logic                 deq_req,
    output logic [QID_NBITS-1:0] deq_qid,
    output logic [NUM_Q-1:0]     backlog_nz,
    output logic                 err_credit_ovf,
    output logic                 err_backlog_ovf
);

    localparam int CW = PIARB_SCH_CREDIT_NBITS;
    localparam int GW = PIARB_SCH_GAP_NBITS;
    localparam logic [CW-1:0]        CREDIT_MAX = CW'(PU_CREDITS);
    localparam logic [GW-1:0]        GAP_LOAD   = GW'(DEQ_GAP - 1);
    localparam logic [CNT_NBITS-1:0] CNT_MAX    = '1;

    logic [CNT_NBITS-1:0] backlog     [NUM_Q];
    logic [CNT_NBITS-1:0] backlog_nxt [NUM_Q];
    logic [CW-1:0]        credit      [NUM_Q];
    logic [CW-1:0]        credit_nxt  [NUM_Q];

    piarb_deq_arb_state_e state;
    logic [QID_NBITS-1:0] rr_ptr;
    logic [GW-1:0]        gap_cnt;

    logic [NUM_Q-1:0]     eligible;
    logic [NUM_Q-1:0]     nz_nxt;
    logic                 found;
    logic [QID_NBITS-1:0] winner;
    logic                 issue;
    logic                 bl_ovf;
    logic                 cr_ovf;

    // A queue competes only with work queued, a PU credit in hand and its enable set.
    always_comb begin
        eligible = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            eligible[q] = (backlog[q] != '0) && (credit[q] != '0) && queue_en[q];
        end
    end

    piarb_rr_pick #(
        .NUM_Q     (NUM_Q),
        .QID_NBITS (QID_NBITS)
    ) u_rr_pick (
        .req   (eligible),
        .start (rr_ptr),
        .found (found),
        .idx   (winner)
    );

    assign issue = (state == IDLE) && sch_en && found;

    // Next-state of per-queue counters; an increment and an issue on the same queue cancel.
    always_comb begin
        logic enq_hit;
        logic done_hit;
        logic deq_hit;
        enq_hit  = 1'b0;
        done_hit = 1'b0;
        deq_hit  = 1'b0;
        bl_ovf   = 1'b0;
        cr_ovf   = 1'b0;
        nz_nxt   = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            enq_hit        = enq_ack && (enq_ack_qid == QID_NBITS'(q));
            done_hit       = pu_fid_done && (pu_id == QID_NBITS'(q));
            deq_hit        = issue && (winner == QID_NBITS'(q));
            backlog_nxt[q] = backlog[q];
            credit_nxt[q]  = credit[q];

            if (enq_hit && !deq_hit) begin
                if (backlog[q] == CNT_MAX) begin
                    bl_ovf = 1'b1;
                end else begin
                    backlog_nxt[q] = backlog[q] + CNT_NBITS'(1);
                end
            end else if (deq_hit && !enq_hit) begin
                backlog_nxt[q] = backlog[q] - CNT_NBITS'(1);
            end

            if (done_hit && !deq_hit) begin
                if (credit[q] == CREDIT_MAX) begin
                    cr_ovf = 1'b1;
                end else begin
                    credit_nxt[q] = credit[q] + CW'(1);
                end
            end else if (deq_hit && !done_hit) begin
                credit_nxt[q] = credit[q] - CW'(1);
            end

            nz_nxt[q] = (backlog_nxt[q] != '0);
        end
    end

    // Counter, backlog-flag and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int q = 0; q < NUM_Q; q++) begin
                backlog[q] <= '0;
                credit[q]  <= CREDIT_MAX;
            end
            backlog_nz      <= '0;
            err_credit_ovf  <= 1'b0;
            err_backlog_ovf <= 1'b0;
        end else begin
            backlog         <= backlog_nxt;
            credit          <= credit_nxt;
            backlog_nz      <= nz_nxt;
            err_credit_ovf  <= err_credit_ovf | cr_ovf;
            err_backlog_ovf <= err_backlog_ovf | bl_ovf;
        end
    end

    // Issue FSM: one-cycle request pulse, then HOLD for the remaining gap cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            rr_ptr  <= '0;
            deq_req <= 1'b0;
            deq_qid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        deq_req <= 1'b1;
                        deq_qid <= winner;
                        rr_ptr  <= (winner == QID_NBITS'(NUM_Q - 1)) ? '0 : winner + QID_NBITS'(1);
                        gap_cnt <= GAP_LOAD;
                        state   <= (DEQ_GAP > 1) ? HOLD : IDLE;
                    end else begin
                        deq_req <= 1'b0;
                    end
                end
                HOLD: begin
                    deq_req <= 1'b0;
                    gap_cnt <= gap_cnt - GW'(1);
                    if (gap_cnt == GW'(1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    deq_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piarb_deq_arb.sv
// tb/tb_piarb_deq_arb.sv - directed self-checking bench for piarb_deq_arb
module tb_piarb_deq_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        sch_en;
    logic [15:0] queue_en;
    logic        enq_ack;
    logic [3:0]  enq_ack_qid;
    logic        pu_fid_done;
    logic [3:0]  pu_id;
    logic        deq_req;
    logic [3:0]  deq_qid;
    logic [15:0] backlog_nz;
    logic        err_credit_ovf;
    logic        err_backlog_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int log_q[$];
    int exp_order[3] = '{0, 5, 15};

    piarb_deq_arb #(
        .NUM_Q      (16),
        .QID_NBITS  (4),
        .CNT_NBITS  (4),
        .PU_CREDITS (2),
        .DEQ_GAP    (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sch_en          (sch_en),
        .queue_en        (queue_en),
        .enq_ack         (enq_ack),
        .enq_ack_qid     (enq_ack_qid),
        .pu_fid_done     (pu_fid_done),
        .pu_id           (pu_id),
        .deq_req         (deq_req),
        .deq_qid         (deq_qid),
        .backlog_nz      (backlog_nz),
        .err_credit_ovf  (err_credit_ovf),
        .err_backlog_ovf (err_backlog_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (deq_req) log_q.push_back(int'(deq_qid));
    endtask

    task automatic run(input int n, input bit repl);
        for (int i = 0; i < n; i++) begin
            tick();
            if (repl && deq_req) begin
                pu_fid_done = 1'b1;
                pu_id       = deq_qid;
            end else begin
                pu_fid_done = 1'b0;
            end
        end
        pu_fid_done = 1'b0;
    endtask

    task automatic enq_n(input logic [3:0] q, input int n);
        enq_ack     = 1'b1;
        enq_ack_qid = q;
        for (int i = 0; i < n; i++) tick();
        enq_ack     = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        sch_en      = 1'b0;
        queue_en    = 16'hFFFF;
        enq_ack     = 1'b0;
        enq_ack_qid = '0;
        pu_fid_done = 1'b0;
        pu_id       = '0;
        tick();
        tick();
        rst = 1'b0;
        log_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        chk("rst_deq_req", deq_req, 0);
        chk("rst_deq_qid", deq_qid, 0);
        chk("rst_backlog_nz", backlog_nz, 0);
        chk("rst_err_credit", err_credit_ovf, 0);
        chk("rst_err_backlog", err_backlog_ovf, 0);

        // Three enqueues to q3, pulses spaced by DEQ_GAP, first at N+2
        sch_en = 1'b1;
        enq_ack = 1'b1; enq_ack_qid = 4'd3;
        tick();
        chk("a_n1_req", deq_req, 0);
        chk("a_n1_nz3", backlog_nz[3], 1);
        tick();
        chk("a_first_req", deq_req, 1);
        chk("a_first_qid", deq_qid, 3);
        pu_fid_done = 1'b1; pu_id = 4'd3;
        tick();
        chk("a_hold_req", deq_req, 0);
        enq_ack = 1'b0; pu_fid_done = 1'b0;
        tick();
        chk("a_second_req", deq_req, 1);
        chk("a_second_qid", deq_qid, 3);
        tick();
        chk("a_hold2_req", deq_req, 0);
        chk("a_hold2_nz3", backlog_nz[3], 1);
        tick();
        chk("a_third_req", deq_req, 1);
        chk("a_third_qid", deq_qid, 3);
        chk("a_third_nz3", backlog_nz[3], 0);
        tick();
        chk("a_after_req", deq_req, 0);

        // Credit stall on q1
        do_reset();
        sch_en = 1'b1;
        enq_n(4'd1, 5);
        run(6, 1'b0);
        chk("b_stall_count", log_q.size(), 2);
        pu_fid_done = 1'b1; pu_id = 4'd1;
        tick();
        pu_fid_done = 1'b0;
        chk("b_done_n1_req", deq_req, 0);
        tick();
        chk("b_done_n2_req", deq_req, 1);
        chk("b_done_n2_qid", deq_qid, 1);

        // Fairness across q0, q5, q15 with wrap
        do_reset();
        enq_n(4'd0, 4);
        enq_n(4'd5, 4);
        enq_n(4'd15, 4);
        tick();
        chk("c_loaded_nz", backlog_nz, 16'h8021);
        sch_en = 1'b1;
        log_q.delete();
        run(30, 1'b1);
        chk("c_issue_count", log_q.size(), 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("c_order_%0d", i), (i < log_q.size()) ? log_q[i] : 32'hFFFF, exp_order[i % 3]);
        end
        chk("c_drained_nz", backlog_nz, 0);
        chk("c_no_credit_err", err_credit_ovf, 0);

        // Simultaneous enqueue and credit return on the issue edge of q2
        do_reset();
        sch_en = 1'b1;
        enq_ack = 1'b1; enq_ack_qid = 4'd2;
        tick();
        chk("d_n1_req", deq_req, 0);
        pu_fid_done = 1'b1; pu_id = 4'd2;
        tick();
        chk("d_issue_req", deq_req, 1);
        chk("d_issue_qid", deq_qid, 2);
        enq_ack = 1'b0; pu_fid_done = 1'b0;
        tick();
        chk("d_hold_req", deq_req, 0);
        chk("d_hold_nz2", backlog_nz[2], 1);
        tick();
        chk("d_second_req", deq_req, 1);
        chk("d_second_qid", deq_qid, 2);
        tick();
        tick();
        chk("d_idle_req", deq_req, 0);
        chk("d_idle_nz2", backlog_nz[2], 0);
        log_q.delete();
        enq_n(4'd2, 2);
        run(6, 1'b0);
        chk("d_credit_kept_count", log_q.size(), 1);
        chk("d_no_credit_err", err_credit_ovf, 0);

        // Error flags
        do_reset();
        sch_en = 1'b1;
        pu_fid_done = 1'b1; pu_id = 4'd4;
        tick();
        pu_fid_done = 1'b0;
        chk("e_credit_ovf_set", err_credit_ovf, 1);
        chk("e_backlog_ovf_clr", err_backlog_ovf, 0);
        log_q.delete();
        enq_n(4'd4, 3);
        run(6, 1'b0);
        chk("e_credit_capped_count", log_q.size(), 2);
        sch_en = 1'b0;
        enq_n(4'd6, 15);
        chk("e_backlog_full_noerr", err_backlog_ovf, 0);
        enq_n(4'd6, 1);
        chk("e_backlog_ovf_set", err_backlog_ovf, 1);
        run(3, 1'b0);
        chk("e_credit_ovf_sticky", err_credit_ovf, 1);
        chk("e_backlog_ovf_sticky", err_backlog_ovf, 1);
        chk("e_sat_nz6", backlog_nz[6], 1);

        // Queue masking, then asynchronous reset mid-pulse
        do_reset();
        chk("f_flags_cleared", {err_credit_ovf, err_backlog_ovf}, 0);
        queue_en = 16'hFF7F;
        sch_en   = 1'b1;
        log_q.delete();
        enq_n(4'd7, 2);
        run(6, 1'b0);
        chk("f_masked_count", log_q.size(), 0);
        chk("f_masked_nz7", backlog_nz[7], 1);
        pu_fid_done = 1'b1; pu_id = 4'd9;
        tick();
        pu_fid_done = 1'b0;
        chk("f_credit_ovf_set", err_credit_ovf, 1);
        queue_en = 16'hFFFF;
        tick();
        chk("f_enabled_req", deq_req, 1);
        chk("f_enabled_qid", deq_qid, 7);
        rst = 1'b1;
        #1;
        chk("f_async_req", deq_req, 0);
        chk("f_async_qid", deq_qid, 0);
        chk("f_async_nz", backlog_nz, 0);
        chk("f_async_flags", {err_credit_ovf, err_backlog_ovf}, 0);
        tick();
        rst = 1'b0;
        sch_en = 1'b1;
        enq_ack = 1'b1; enq_ack_qid = 4'd8;
        tick();
        enq_ack = 1'b0;
        chk("f_post_n1_req", deq_req, 0);
        tick();
        chk("f_post_n2_req", deq_req, 1);
        chk("f_post_n2_qid", deq_qid, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
